// File: rtl/gt_victim_buf.sv
// rtl/gt_victim_buf.sv - fully-associative victim buffer with a single-line writeback buffer
// Lookups hit-and-invalidate (swap to L1); dirty round-robin victims drain through wb_*.
module gt_victim_buf #(
  parameter int ENTRIES = 4,
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int OFF_W   = 5
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         lk_valid,
  input  logic [ADDR_W-1:0]            lk_addr,
  output logic                         lk_done,
  output logic                         lk_hit,
  output logic                         lk_dirty,
  output logic [LINE_W-1:0]            lk_data,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  input  logic [ADDR_W-1:0]            ins_addr,
  input  logic [LINE_W-1:0]            ins_data,
  input  logic                         ins_dirty,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [LINE_W-1:0]            wb_data,
  output logic [$clog2(ENTRIES):0]     occupancy
);

  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;

  typedef enum logic {S_IDLE, S_WB_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [ENTRIES-1:0]  r_valid;
  logic [ENTRIES-1:0]  r_dirty;
  logic [TAG_W-1:0]    r_tag  [ENTRIES];
  logic [LINE_W-1:0]   r_data [ENTRIES];
  logic [IDX_W-1:0]    r_rr_ptr;

  logic [ADDR_W-1:0]   r_wb_addr;
  logic [LINE_W-1:0]   r_wb_data;

  logic                r_lk_done;
  logic                r_lk_hit;
  logic                r_lk_dirty;
  logic [LINE_W-1:0]   r_lk_data;

  logic [TAG_W-1:0]    w_lk_tag;
  logic [TAG_W-1:0]    w_ins_tag;
  logic                w_lk_ent_hit;
  logic [IDX_W-1:0]    w_lk_idx;
  logic                w_lk_wb_hit;
  logic                w_lk_kill;
  logic [ENTRIES-1:0]  w_free;
  logic                w_ins_fire;
  logic                w_merge;
  logic [IDX_W-1:0]    w_merge_idx;
  logic                w_has_free;
  logic [IDX_W-1:0]    w_free_idx;
  logic [IDX_W-1:0]    w_ins_idx;
  logic                w_replace;
  logic                w_wb_load;
  logic [OCC_W-1:0]    w_occ;
  logic                w_unused;

  assign w_lk_tag   = lk_addr[ADDR_W-1:OFF_W];
  assign w_ins_tag  = ins_addr[ADDR_W-1:OFF_W];
  assign w_unused   = ^{lk_addr[OFF_W-1:0], ins_addr[OFF_W-1:0]};

  assign wb_valid   = (r_state == S_WB_WAIT);
  assign ins_ready  = !wb_valid;
  assign w_ins_fire = ins_valid && ins_ready;

  // Tags are unique among valid entries, so the lowest matching index is the only one.
  always_comb begin
    w_lk_ent_hit = 1'b0;
    w_lk_idx     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_lk_tag)) begin
        w_lk_ent_hit = 1'b1;
        w_lk_idx     = IDX_W'(i);
      end
    end
  end

  assign w_lk_wb_hit = wb_valid && (r_wb_addr[ADDR_W-1:OFF_W] == w_lk_tag);
  assign w_lk_kill   = lk_valid && w_lk_ent_hit;

  // An entry being swapped out by this cycle's lookup is already free for the insert.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      w_free[i] = !r_valid[i] || (w_lk_kill && (w_lk_idx == IDX_W'(i)));
    end
  end

  always_comb begin
    w_merge     = 1'b0;
    w_merge_idx = '0;
    w_has_free  = 1'b0;
    w_free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!w_free[i] && (r_tag[i] == w_ins_tag)) begin
        w_merge     = 1'b1;
        w_merge_idx = IDX_W'(i);
      end
      if (w_free[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_ins_idx = r_rr_ptr;
    if (w_merge) begin
      w_ins_idx = w_merge_idx;
    end else if (w_has_free) begin
      w_ins_idx = w_free_idx;
    end
  end

  assign w_replace = w_ins_fire && !w_merge && !w_has_free;
  assign w_wb_load = w_replace && r_dirty[r_rr_ptr];

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_occ = w_occ + OCC_W'(r_valid[i]);
    end
  end
  assign occupancy = w_occ;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_wb_load) w_state_nxt = S_WB_WAIT;
      S_WB_WAIT: if (wb_ready)  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Invalidate-on-hit is written first so an insert into the same slot wins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid  <= '0;
      r_dirty  <= '0;
      r_rr_ptr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_lk_kill) begin
        r_valid[w_lk_idx] <= 1'b0;
      end
      if (w_ins_fire) begin
        r_valid[w_ins_idx] <= 1'b1;
        r_tag[w_ins_idx]   <= w_ins_tag;
        r_data[w_ins_idx]  <= ins_data;
        r_dirty[w_ins_idx] <= w_merge ? (r_dirty[w_ins_idx] | ins_dirty) : ins_dirty;
      end
      if (w_replace) begin
        r_rr_ptr <= r_rr_ptr + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (w_wb_load) begin
      r_wb_addr <= {r_tag[r_rr_ptr], {OFF_W{1'b0}}};
      r_wb_data <= r_data[r_rr_ptr];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lk_done  <= 1'b0;
      r_lk_hit   <= 1'b0;
      r_lk_dirty <= 1'b0;
      r_lk_data  <= '0;
    end else begin
      r_lk_done  <= lk_valid;
      r_lk_hit   <= lk_valid && (w_lk_ent_hit || w_lk_wb_hit);
      r_lk_dirty <= w_lk_kill && r_dirty[w_lk_idx];
      if (w_lk_kill) begin
        r_lk_data <= r_data[w_lk_idx];
      end else if (lk_valid && w_lk_wb_hit) begin
        r_lk_data <= r_wb_data;
      end else begin
        r_lk_data <= '0;
      end
    end
  end

  assign lk_done  = r_lk_done;
  assign lk_hit   = r_lk_hit;
  assign lk_dirty = r_lk_dirty;
  assign lk_data  = r_lk_data;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;

endmodule

// File: tb/tb_gt_victim_buf.sv
// tb/tb_gt_victim_buf.sv - scoreboard bench for gt_victim_buf against a line-level model
module tb_gt_victim_buf;
  localparam int ENTRIES = 4;
  localparam int LINE_W  = 256;
  localparam int ADDR_W  = 32;
  localparam int OFF_W   = 5;
  localparam int TAG_W   = ADDR_W - OFF_W;

  typedef logic [LINE_W-1:0] line_t;
  typedef struct { logic hit; logic dirty; line_t data; } lk_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; line_t data; } wb_exp_t;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic                  lk_valid = 1'b0;
  logic [ADDR_W-1:0]     lk_addr = '0;
  logic                  lk_done, lk_hit, lk_dirty;
  line_t                 lk_data;
  logic                  ins_valid = 1'b0;
  logic                  ins_ready;
  logic [ADDR_W-1:0]     ins_addr = '0;
  line_t                 ins_data = '0;
  logic                  ins_dirty = 1'b0;
  logic                  wb_valid;
  logic                  wb_ready = 1'b1;
  logic [ADDR_W-1:0]     wb_addr;
  line_t                 wb_data;
  logic [$clog2(ENTRIES):0] occupancy;

  gt_victim_buf #(.ENTRIES(ENTRIES), .LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_done(lk_done), .lk_hit(lk_hit),
    .lk_dirty(lk_dirty), .lk_data(lk_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_addr(ins_addr),
    .ins_data(ins_data), .ins_dirty(ins_dirty),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  lk_exp_t lk_q[$];
  wb_exp_t wb_q[$];

  bit                m_v   [ENTRIES];
  bit                m_d   [ENTRIES];
  logic [TAG_W-1:0]  m_t   [ENTRIES];
  line_t             m_dat [ENTRIES];
  int                m_rr;
  bit                m_wbv;
  logic [ADDR_W-1:0] m_wba;
  line_t             m_wbd;

  task automatic chk(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) n += m_v[i] ? 1 : 0;
    return n;
  endfunction

  function automatic line_t rnd_line();
    line_t r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] mk_addr(input int tag, input int off);
    return (ADDR_W'(tag) << OFF_W) | ADDR_W'(off % (1 << OFF_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_v[i] = 0; m_d[i] = 0; m_t[i] = '0; m_dat[i] = '0;
    end
    m_rr = 0; m_wbv = 0; m_wba = '0; m_wbd = '0;
    lk_q.delete();
    wb_q.delete();
  endtask

  // Applies one clock edge worth of behaviour, using pre-edge state for every decision.
  task automatic model_step();
    logic [TAG_W-1:0] lt, it;
    int h, slot;
    bit ins_fire, wb_done;
    lk_exp_t e;
    lt = lk_addr[ADDR_W-1:OFF_W];
    it = ins_addr[ADDR_W-1:OFF_W];
    h = -1;
    slot = -1;
    ins_fire = ins_valid && !m_wbv;
    wb_done = m_wbv && wb_ready;
    for (int i = 0; i < ENTRIES; i++) if (h < 0 && m_v[i] && m_t[i] == lt) h = i;
    if (lk_valid) begin
      if (h >= 0) e = '{1'b1, m_d[h], m_dat[h]};
      else if (m_wbv && m_wba[ADDR_W-1:OFF_W] == lt) e = '{1'b1, 1'b0, m_wbd};
      else e = '{1'b0, 1'b0, '0};
      lk_q.push_back(e);
      if (h >= 0) m_v[h] = 0;
    end
    if (wb_done) m_wbv = 0;
    if (ins_fire) begin
      for (int i = 0; i < ENTRIES; i++) if (slot < 0 && m_v[i] && m_t[i] == it) slot = i;
      if (slot >= 0) begin
        m_dat[slot] = ins_data;
        m_d[slot] = m_d[slot] | ins_dirty;
      end else begin
        for (int i = 0; i < ENTRIES; i++) if (slot < 0 && !m_v[i]) slot = i;
        if (slot < 0) begin
          slot = m_rr;
          if (m_d[slot]) begin
            m_wbv = 1;
            m_wba = {m_t[slot], {OFF_W{1'b0}}};
            m_wbd = m_dat[slot];
            wb_q.push_back('{m_wba, m_wbd});
          end
          m_rr = (m_rr + 1) % ENTRIES;
        end
        m_v[slot] = 1; m_t[slot] = it; m_dat[slot] = ins_data; m_d[slot] = ins_dirty;
      end
    end
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      chk("occupancy", line_t'(occupancy), line_t'(m_occ()));
      chk("wb_valid", line_t'(wb_valid), line_t'(m_wbv));
      chk("ins_ready", line_t'(ins_ready), line_t'(!m_wbv));
      if (m_wbv) begin
        chk("wb_addr", line_t'(wb_addr), line_t'(m_wba));
        chk("wb_data", wb_data, m_wbd);
      end
      if (lk_done) begin
        if (lk_q.size() == 0) begin
          fail_now("lk_done_spurious");
        end else begin
          lk_exp_t e;
          e = lk_q.pop_front();
          chk("lk_hit", line_t'(lk_hit), line_t'(e.hit));
          chk("lk_dirty", line_t'(lk_dirty), line_t'(e.dirty));
          chk("lk_data", lk_data, e.data);
        end
      end else if (lk_q.size() != 0) begin
        void'(lk_q.pop_front());
        fail_now("lk_done_missing");
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          fail_now("wb_spurious");
        end else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          chk("wb_hs_addr", line_t'(wb_addr), line_t'(w.addr));
          chk("wb_hs_data", wb_data, w.data);
        end
      end
    end
  end

  task automatic step(input bit lv, input logic [ADDR_W-1:0] la, input bit iv,
                      input logic [ADDR_W-1:0] ia, input line_t idat, input bit idr,
                      input bit wr);
    lk_valid = lv; lk_addr = la;
    ins_valid = iv; ins_addr = ia; ins_data = idat; ins_dirty = idr;
    wb_ready = wr;
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle(input bit wr);
    step(0, '0, 0, '0, '0, 0, wr);
  endtask

  task automatic do_reset();
    lk_valid = 0; ins_valid = 0; wb_ready = 1;
    RST_N = 1'b0;
    #1;
    mon_en = 0;
    chk("rst_wb_valid", line_t'(wb_valid), line_t'(0));
    chk("rst_occupancy", line_t'(occupancy), line_t'(0));
    chk("rst_ins_ready", line_t'(ins_ready), line_t'(1));
    chk("rst_lk_done", line_t'(lk_done), line_t'(0));
    chk("rst_lk_hit", line_t'(lk_hit), line_t'(0));
    chk("rst_lk_data", lk_data, line_t'(0));
    chk("rst_wb_addr", line_t'(wb_addr), line_t'(0));
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    mon_en = 1;
  endtask

  task automatic fill_dirty(input int base);
    for (int i = 0; i < ENTRIES; i++) step(0, '0, 1, mk_addr(base + i, 0), rnd_line(), 1, 1);
  endtask

  initial begin
    line_t d1;
    model_reset();
    #12;
    do_reset();

    // Insert dirty, lookup with nonzero offset: hit, dirty, data, occupancy back to 0
    d1 = rnd_line();
    step(0, '0, 1, 32'h1000, d1, 1, 1);
    step(1, 32'h101F, 0, '0, '0, 0, 1);
    idle(1);

    // Five clean inserts: fifth replaces entry 0 silently; sixth then replaces entry 1
    do_reset();
    for (int i = 0; i < 5; i++) step(0, '0, 1, mk_addr(16'h200 + i, 3), rnd_line(), 0, 1);
    chk("clean_fill_occ", line_t'(occupancy), line_t'(4));
    step(0, '0, 1, mk_addr(16'h300, 0), rnd_line(), 0, 1);
    for (int i = 0; i < 6; i++) step(1, mk_addr(16'h200 + i, 7), 0, '0, '0, 0, 1);
    step(1, mk_addr(16'h300, 1), 0, '0, '0, 0, 1);
    idle(1);

    // Dirty replacement held for three cycles while a blocked insert is offered
    do_reset();
    fill_dirty(16'h400);
    step(0, '0, 1, mk_addr(16'h500, 0), rnd_line(), 1, 0);
    chk("wb_wait_valid", line_t'(wb_valid), line_t'(1));
    for (int i = 0; i < 3; i++) step(0, '0, 1, mk_addr(16'h600, 0), rnd_line(), 0, 0);
    step(0, '0, 0, '0, '0, 0, 1);
    idle(1);
    chk("wb_cleared", line_t'(wb_valid), line_t'(0));

    // Lookup hits the writeback buffer, then writeback still drains
    do_reset();
    fill_dirty(16'h700);
    step(0, '0, 1, mk_addr(16'h800, 0), rnd_line(), 1, 0);
    step(1, mk_addr(16'h700, 9), 0, '0, '0, 0, 0);
    step(0, '0, 0, '0, '0, 0, 1);
    idle(1);

    // Same-cycle hit on entry 2 and insert of a new tag: lands in entry 2, no writeback
    do_reset();
    fill_dirty(16'h900);
    step(1, mk_addr(16'h902, 0), 1, mk_addr(16'hA00, 0), rnd_line(), 1, 1);
    idle(1);
    chk("swap_occ", line_t'(occupancy), line_t'(4));
    // Same tag on both sides: lookup sees old line, insert reallocates
    step(1, mk_addr(16'h901, 0), 1, mk_addr(16'h901, 4), rnd_line(), 0, 1);
    step(1, mk_addr(16'h901, 0), 0, '0, '0, 0, 1);
    idle(1);

    // Reset asserted while a writeback is pending
    do_reset();
    fill_dirty(16'hB00);
    step(0, '0, 1, mk_addr(16'hC00, 0), rnd_line(), 1, 0);
    chk("pre_rst_wb_valid", line_t'(wb_valid), line_t'(1));
    do_reset();

    // Random traffic over a small tag pool so hits, merges and replacements all occur
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 1), mk_addr($urandom_range(0, 9), $urandom),
           $urandom_range(0, 1), mk_addr($urandom_range(0, 9), $urandom),
           rnd_line(), $urandom_range(0, 1), $urandom_range(0, 2) != 0);
    end
    idle(1);
    idle(1);
    idle(1);
    chk("lk_q_drained", line_t'(lk_q.size()), line_t'(0));
    chk("wb_q_drained", line_t'(wb_q.size()), line_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
